sp_ram_arb: RTL and testbench

Parametrised single-port, byte-enabled SRAM model with an integrated round-robin arbiter serving `NUM_PORTS` request/grant/rvalid masters (instruction fetch, load/store, debug) in one clock domain. It is the next-generation core-local memory: generalised width, depth and port count, with a handshake and an optional hardware zero-clear sequence after reset. It sits between the core's memory interfaces and the simulation/FPGA memory macro.

---
 rtl/sp_ram_arb.sv | 167 ++++++++++++++++
 tb/tb_sp_ram_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arb.sv
// -----------------------------------------------------------------------------
// sp_ram_arb
// Single-port, byte-enabled SRAM model shared by NUM_PORTS masters through a
// round-robin arbiter. One transaction per cycle across all ports.
//
// Optional feature: define SP_RAM_ARB_CLEAR_EN to build an init FSM that
// zero-fills every word after reset (busy_o high while it runs). Without the
// macro busy_o is tied low and the memory powers up with unknown contents.
//
// Ports (packed arrays are indexed by port number):
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   req_i     in   [NUM_PORTS]             access request
//   gnt_o     out  [NUM_PORTS]             request accepted this cycle
//   addr_i    in   [NUM_PORTS][ADDR_WIDTH] byte address
//   we_i      in   [NUM_PORTS]             1 = write, 0 = read
//   be_i      in   [NUM_PORTS][DATA_WIDTH/8] write byte enables
//   wdata_i   in   [NUM_PORTS][DATA_WIDTH] write data
//   rvalid_o  out  [NUM_PORTS]             response for previous grant
//   rdata_o   out  [NUM_PORTS][DATA_WIDTH] read-first word, held until next
//                                          response to that port
//   busy_o    out  clear sequence running, no grants
//
// Handshake: a master raises req_i and holds req/addr/we/be/wdata stable until
// it sees gnt_o high in the same cycle; that cycle's rising edge performs the
// access, and rvalid_o pulses for exactly one cycle right after that edge with
// rdata_o carrying the word as it was before the edge. Keeping req_i high after
// a grant issues a new transaction.
// -----------------------------------------------------------------------------
module sp_ram_arb #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 1024,
  parameter int NUM_PORTS  = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_PORTS-1:0]                     req_i,
  output logic [NUM_PORTS-1:0]                     gnt_o,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_PORTS-1:0]                     we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   be_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_PORTS-1:0]                     rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     rdata_o,
  output logic                                     busy_o
);

  localparam int BE    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr_nxt;
  logic             gnt_any;
  logic [IDX_W-1:0] widx;

  // Byte-offset and above-depth address bits are intentionally ignored; the
  // reduction keeps every address bit visibly consumed.
  logic unused_addr;
  assign unused_addr = ^addr_i;

  // ---------------------------------------------------------------------------
  // Optional zero-clear sequence
  // ---------------------------------------------------------------------------
`ifdef SP_RAM_ARB_CLEAR_EN
  typedef enum logic {CLEAR, READY} init_state_t;

  init_state_t      state, state_nxt;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == IDX_W'(NUM_WORDS - 1)) state_nxt = READY;
      end
      READY: ;
      default: state_nxt = CLEAR;
    endcase
  end

  assign busy_o = (state == CLEAR);
`else
  assign busy_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first requester at or after rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = PTR_W'(cand);
      if (!gnt_any && req_i[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    // Reset and the clear sequence both block every grant.
    if (rst || busy_o) gnt_any = 1'b0;
  end

  always_comb begin
    gnt_o = '0;
    if (gnt_any) gnt_o[gnt_idx] = 1'b1;
  end

  assign ptr_nxt = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
  assign widx    = addr_i[gnt_idx][OFF_W +: IDX_W];

  // ---------------------------------------------------------------------------
  // Memory array (not reset; cleared only by the optional sequence)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
`ifdef SP_RAM_ARB_CLEAR_EN
    if (state == CLEAR) mem[clr_cnt] <= '0;
`endif
    if (gnt_any && we_i[gnt_idx]) begin
      for (int k = 0; k < BE; k++) begin
        if (be_i[gnt_idx][k]) mem[widx][8*k +: 8] <= wdata_i[gnt_idx][8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response path and arbitration pointer. The read sees the array before the
  // same edge's write, which gives read-first behaviour for writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
      rr_ptr   <= '0;
    end else begin
      rvalid_o <= gnt_o;
      if (gnt_any) begin
        rdata_o[gnt_idx] <= mem[widx];
        rr_ptr           <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_arb
// Directed bench for sp_ram_arb with default parameters (2 ports, 32-bit
// words, 1024 words). A table of per-cycle vectors covers writes, byte
// enables, read-first data, address aliasing and round-robin alternation;
// hand-written sequences cover reset behaviour and, when SP_RAM_ARB_CLEAR_EN
// is defined, the zero-clear sequence and its restart.
// -----------------------------------------------------------------------------
module tb_sp_ram_arb;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NW = 1024;
  localparam int NP = 2;

  // ---------------------------------------------------------------------------
  // Clock and DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]               req;
  logic [NP-1:0]               gnt;
  logic [NP-1:0][AW-1:0]       addr;
  logic [NP-1:0]               we;
  logic [NP-1:0][DW/8-1:0]     be;
  logic [NP-1:0][DW-1:0]       wdata;
  logic [NP-1:0]               rvalid;
  logic [NP-1:0][DW-1:0]       rdata;
  logic                        busy;

  sp_ram_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .NUM_PORTS  (NP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .addr_i   (addr),
    .we_i     (we),
    .be_i     (be),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .busy_o   (busy)
  );

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [1:0]  gnt;   // expected grant in the cycle
    logic [1:0]  rv;    // expected rvalid after the edge
    logic [1:0]  chk;   // which ports' rdata to compare after the edge
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t vq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_row(input logic [1:0] r, input logic [1:0] w,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [3:0] b0, input logic [3:0] b1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] g, input logic [1:0] v, input logic [1:0] c,
                         input logic [31:0] e0, input logic [31:0] e1);
    vec_t t;
    t.req = r;  t.we = w;  t.a0 = a0;  t.a1 = a1;  t.be0 = b0;  t.be1 = b1;
    t.wd0 = d0; t.wd1 = d1; t.gnt = g; t.rv = v;  t.chk = c;  t.rd0 = e0; t.rd1 = e1;
    vq.push_back(t);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input vec_t v);
    req      = v.req;
    we       = v.we;
    addr[0]  = v.a0;
    addr[1]  = v.a1;
    be[0]    = v.be0;
    be[1]    = v.be1;
    wdata[0] = v.wd0;
    wdata[1] = v.wd1;
  endtask

  // Drives shortly after a rising edge, checks the combinational grant near
  // the falling edge, then checks the registered response just after the
  // next rising edge.
  task automatic apply_vec(input vec_t v, input string tag);
    drive(v);
    #4;
    check({tag, "_gnt"}, {30'b0, gnt}, {30'b0, v.gnt});
    @(posedge clk);
    #1;
    check({tag, "_rvalid"}, {30'b0, rvalid}, {30'b0, v.rv});
    if (v.chk[0]) check({tag, "_rdata0"}, rdata[0], v.rd0);
    if (v.chk[1]) check({tag, "_rdata1"}, rdata[1], v.rd1);
  endtask

  function automatic vec_t mk(input logic [1:0] r, input logic [15:0] a0, input logic [15:0] a1,
                              input logic [1:0] g, input logic [1:0] v, input logic [1:0] c,
                              input logic [31:0] e0);
    vec_t t;
    t.req = r;   t.we = 2'b00; t.a0 = a0;  t.a1 = a1;  t.be0 = 4'h0; t.be1 = 4'h0;
    t.wd0 = '0;  t.wd1 = '0;   t.gnt = g;  t.rv = v;   t.chk = c;    t.rd0 = e0;
    t.rd1 = '0;
    return t;
  endfunction

`ifdef SP_RAM_ARB_CLEAR_EN
  // Counts busy cycles after reset release with both ports requesting;
  // bounded at twice the expected length.
  task automatic wait_ready(input string tag);
    int   cnt;
    logic gbad;
    cnt  = 0;
    gbad = 1'b0;
    drive(mk(2'b11, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 32'h0));
    for (int c = 0; c < 2 * NW + 4; c++) begin
      #1;
      if (!busy) break;
      cnt++;
      if (gnt !== 2'b00) gbad = 1'b1;
      @(posedge clk);
      #1;
    end
    check({tag, "_busy_cycles"}, cnt, NW);
    check({tag, "_gnt_while_busy"}, {31'b0, gbad}, 32'h0);
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    logic        exp_busy_rst;
    logic [31:0] exp_after_rst;
`ifdef SP_RAM_ARB_CLEAR_EN
    logic [15:0] zaddr [3];
    exp_busy_rst  = 1'b1;
    exp_after_rst = 32'h0000_0000;
`else
    exp_busy_rst  = 1'b0;
    exp_after_rst = 32'hDEAD_BEAA;
`endif

    //       req   we    a0       a1       be0   be1   wd0           wd1           gnt   rv    chk   rd0           rd1
    add_row(2'b01,2'b01,16'h0010,16'h0000,4'hF,4'h0,32'hDEADBEEF,32'h0,        2'b01,2'b01,2'b00,32'h0,        32'h0);
    add_row(2'b01,2'b01,16'h0010,16'h0000,4'h1,4'h0,32'h000000AA,32'h0,        2'b01,2'b01,2'b01,32'hDEADBEEF,32'h0);
    add_row(2'b01,2'b00,16'h0010,16'h0000,4'h0,4'h0,32'h0,        32'h0,        2'b01,2'b01,2'b01,32'hDEADBEAA,32'h0);
    add_row(2'b10,2'b10,16'h0000,16'h1003,4'h0,4'hF,32'h0,        32'h12345678,2'b10,2'b10,2'b00,32'h0,        32'h0);
    add_row(2'b01,2'b00,16'h0000,16'h0000,4'h0,4'h0,32'h0,        32'h0,        2'b01,2'b01,2'b01,32'h12345678,32'h0);
    add_row(2'b10,2'b10,16'h0000,16'h0000,4'h0,4'h0,32'h0,        32'hFFFFFFFF,2'b10,2'b10,2'b10,32'h0,        32'h12345678);
    add_row(2'b10,2'b00,16'h0000,16'h0000,4'h0,4'h0,32'h0,        32'h0,        2'b10,2'b10,2'b10,32'h0,        32'h12345678);
    add_row(2'b00,2'b00,16'h0000,16'h0000,4'h0,4'h0,32'h0,        32'h0,        2'b00,2'b00,2'b11,32'h12345678,32'h12345678);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] g;
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      add_row(2'b11,2'b00,16'h0010,16'h0000,4'h0,4'h0,32'h0,      32'h0,        g,    g,    g,    32'hDEADBEAA,32'h12345678);
    end
    add_row(2'b00,2'b00,16'h0000,16'h0000,4'h0,4'h0,32'h0,        32'h0,        2'b00,2'b00,2'b11,32'hDEADBEAA,32'h12345678);
    add_row(2'b10,2'b10,16'h0000,16'h0020,4'h0,4'hF,32'h0,        32'h11223344,2'b10,2'b10,2'b00,32'h0,        32'h0);
    add_row(2'b10,2'b10,16'h0000,16'h0022,4'h0,4'hA,32'h0,        32'hAABBCCDD,2'b10,2'b10,2'b10,32'h0,        32'h11223344);
    add_row(2'b01,2'b00,16'h0020,16'h0000,4'h0,4'h0,32'h0,        32'h0,        2'b01,2'b01,2'b01,32'hAA22CC44,32'h0);

    // Reset state, with both ports requesting to show grants are forced low.
    drive(mk(2'b11, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 32'h0));
    #1 rst = 1'b1;
    @(posedge clk);
    #4;
    check("rst_gnt",    {30'b0, gnt},    32'h0);
    check("rst_rvalid", {30'b0, rvalid}, 32'h0);
    check("rst_rdata0", rdata[0],        32'h0);
    check("rst_rdata1", rdata[1],        32'h0);
    check("rst_busy",   {31'b0, busy},   {31'b0, exp_busy_rst});
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef SP_RAM_ARB_CLEAR_EN
    wait_ready("init");
    zaddr[0] = 16'h0000;
    zaddr[1] = 16'h0800;
    zaddr[2] = 16'(4 * (NW - 1));
    foreach (zaddr[i])
      apply_vec(mk(2'b01, zaddr[i], 16'h0000, 2'b01, 2'b01, 2'b01, 32'h0),
                $sformatf("clear_rd%0d", i));
`else
    check("busy_low", {31'b0, busy}, 32'h0);
    apply_vec(mk(2'b01, 16'h0000, 16'h0000, 2'b01, 2'b01, 2'b00, 32'h0), "first_grant");
`endif

    foreach (vq[i]) apply_vec(vq[i], $sformatf("row%0d", i));

    // Reset with a response pending: rvalid drops and rr_ptr returns to 0.
    drive(mk(2'b01, 16'h0010, 16'h0000, 2'b00, 2'b00, 2'b00, 32'h0));
    #4;
    check("mid_gnt", {30'b0, gnt}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rvalid_drop", {30'b0, rvalid}, 32'h0);
    check("mid_rdata_clr",   rdata[0],        32'h0);
    drive(mk(2'b11, 16'h0010, 16'h0000, 2'b00, 2'b00, 2'b00, 32'h0));
    #1;
    check("mid_gnt_in_rst", {30'b0, gnt}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef SP_RAM_ARB_CLEAR_EN
    wait_ready("after_mid");
`endif
    apply_vec(mk(2'b11, 16'h0010, 16'h0000, 2'b01, 2'b01, 2'b01, exp_after_rst), "rr_after_rst");

`ifdef SP_RAM_ARB_CLEAR_EN
    // Reset pulsed part-way through the clear restarts the full sequence.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("restart_busy_at7", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_ready("restart");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
